// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, state encoding and address field helpers for
// the direct-mapped write-back data cache (dcache_ctrl, dcache_line_store).
//   Address layout (8 bits): {tag[3:0], index[2:0], offset}
//   A block is two bytes; offset 0 selects block[7:0], offset 1 block[15:8].
package dcache_pkg;

    localparam int TAG_W   = 4;
    localparam int INDEX_W = 3;
    localparam int OFFS_W  = 1;
    localparam int ADDR_W  = TAG_W + INDEX_W + OFFS_W;
    localparam int MADDR_W = TAG_W + INDEX_W;
    localparam int LINES   = 1 << INDEX_W;
    localparam int BLOCK_W = 16;
    localparam int WORD_W  = 8;

    // Controller states. Kept as plain constants so the encoding stays
    // visible and stable for downstream tools that match on state codes.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WRITEBACK = 2'd1;
    localparam state_t ST_ALLOCATE  = 2'd2;
    localparam state_t ST_UPDATE    = 2'd3;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFS_W +: INDEX_W];
    endfunction

    function automatic logic addr_offset(input logic [ADDR_W-1:0] a);
        return a[0];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: per-line valid/dirty/tag/data storage.
//   clk_i, rst_i    : clock, async active-low reset (clears valid and dirty)
//   index_i         : line selected for both the read and the write port
//   valid_o, dirty_o, tag_o, data_o : asynchronous read of the selected line
//   wr_en_i         : commit a write on the next posedge
//   fill_i          : 1 = whole-block fill (tag_i/block_i, valid=1, dirty=0)
//                     0 = byte store (byte_i at offset_i, dirty=1)
module dcache_line_store import dcache_pkg::*; #(
    parameter int TAG_W   = dcache_pkg::TAG_W,
    parameter int INDEX_W = dcache_pkg::INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index_i,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [BLOCK_W-1:0] data_o,
    input  logic               wr_en_i,
    input  logic               fill_i,
    input  logic               offset_i,
    input  logic [WORD_W-1:0]  byte_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [BLOCK_W-1:0] block_i
);

    localparam int N = 1 << INDEX_W;

    logic [N-1:0]              valid_q;
    logic [N-1:0]              dirty_q;
    logic [N-1:0][TAG_W-1:0]   tag_q;
    logic [N-1:0][BLOCK_W-1:0] data_q;

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign data_o  = data_q[index_i];

    // Only the status bits need a reset; tag/data are qualified by valid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            // Byte stores only happen on a hit, so valid is already 1 there.
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= !fill_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (fill_i) begin
                tag_q[index_i]  <= tag_i;
                data_q[index_i] <= block_i;
            end else if (offset_i) begin
                data_q[index_i][BLOCK_W-1 -: WORD_W] <= byte_i;
            end else begin
                data_q[index_i][WORD_W-1:0] <= byte_i;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, direct-mapped data cache controller, 8 lines of one
// 16-bit block. Hits complete with no stall; misses write back a dirty victim,
// fetch the block, refill the line and then retire as a hit.
//   clk_i, rst_i            : clock, async active-low reset
//   read_i, write_i         : processor load/store (both high = no-op)
//   address_i, write_data_i : byte address {tag,index,offset}, store byte
//   read_data_o             : load byte (combinational)
//   busy_wait_o             : processor stall
//   mem_read_o, mem_write_o : block fetch / write-back request
//   mem_address_o           : block address {tag,index}
//   mem_write_data_o        : victim block
//   mem_read_data_i         : fetched block
//   mem_busy_wait_i         : memory busy
module dcache_ctrl import dcache_pkg::*; #(
    parameter int TAG_W   = dcache_pkg::TAG_W,
    parameter int INDEX_W = dcache_pkg::INDEX_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       read_i,
    input  logic                       write_i,
    input  logic [TAG_W+INDEX_W:0]     address_i,
    input  logic [WORD_W-1:0]          write_data_i,
    output logic [WORD_W-1:0]          read_data_o,
    output logic                       busy_wait_o,
    output logic                       mem_read_o,
    output logic                       mem_write_o,
    output logic [TAG_W+INDEX_W-1:0]   mem_address_o,
    output logic [BLOCK_W-1:0]         mem_write_data_o,
    input  logic [BLOCK_W-1:0]         mem_read_data_i,
    input  logic                       mem_busy_wait_i
);

    state_t state_q, state_d;
    // Set once the current memory state has lasted one cycle; the memory
    // raises its busy flag a cycle after the request, so the first cycle's
    // idle busy flag must not be taken as completion.
    logic   dwell_q, dwell_d;

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               offset;
    logic               line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               req, hit, miss;
    logic               st_wr_en, st_fill;

    assign tag    = addr_tag(address_i);
    assign index  = addr_index(address_i);
    assign offset = addr_offset(address_i);

    assign req  = read_i ^ write_i;
    assign hit  = line_valid && (line_tag == tag);
    assign miss = req && !hit;

    always_comb begin
        state_d = state_q;
        dwell_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                dwell_d = 1'b0;
                if (miss) state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: begin
                if (dwell_q && !mem_busy_wait_i) begin
                    state_d = ST_ALLOCATE;
                    dwell_d = 1'b0;
                end
            end
            ST_ALLOCATE: begin
                if (dwell_q && !mem_busy_wait_i) begin
                    state_d = ST_UPDATE;
                    dwell_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            dwell_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Line writes: refill in UPDATE, byte store on an IDLE store hit.
    assign st_fill  = (state_q == ST_UPDATE);
    assign st_wr_en = st_fill || ((state_q == ST_IDLE) && write_i && !read_i && hit);

    dcache_line_store #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W)
    ) u_store (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .index_i  (index),
        .valid_o  (line_valid),
        .dirty_o  (line_dirty),
        .tag_o    (line_tag),
        .data_o   (line_data),
        .wr_en_i  (st_wr_en),
        .fill_i   (st_fill),
        .offset_i (offset),
        .byte_i   (write_data_i),
        .tag_i    (tag),
        .block_i  (mem_read_data_i)
    );

    assign read_data_o = offset ? line_data[BLOCK_W-1 -: WORD_W] : line_data[WORD_W-1:0];

    // Memory requests come from state only; the address is held stable by the
    // processor for the whole miss.
    assign mem_write_o      = (state_q == ST_WRITEBACK);
    assign mem_read_o       = (state_q == ST_ALLOCATE);
    assign mem_address_o    = mem_write_o ? {line_tag, index} : address_i[TAG_W+INDEX_W:1];
    assign mem_write_data_o = line_data;

    // Held low while in reset even if a request is still presented.
    assign busy_wait_o = rst_i && ((state_q != ST_IDLE) || miss);

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        read, write;
    logic [7:0]  address, write_data, read_data;
    logic        busy_wait, mem_read, mem_write, mem_busy_wait;
    logic [6:0]  mem_address;
    logic [15:0] mem_write_data, mrdata;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .read_i           (read),
        .write_i          (write),
        .address_i        (address),
        .write_data_i     (write_data),
        .read_data_o      (read_data),
        .busy_wait_o      (busy_wait),
        .mem_read_o       (mem_read),
        .mem_write_o      (mem_write),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mrdata),
        .mem_busy_wait_i  (mem_busy_wait)
    );

    // ---------------- memory responder ----------------
    // A new request starts a transaction at the next posedge; busy stays high
    // for lat+1 posedges, then the block is read/written and busy drops.
    logic [15:0] bus_mem [128];
    logic        mbusy;
    logic [1:0]  served;
    int          mcnt;
    int          lat;

    assign mem_busy_wait = mbusy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbusy  <= 1'b0;
            served <= 2'b00;
            mcnt   <= 0;
            mrdata <= '0;
        end else if (mbusy) begin
            if (mcnt == 0) begin
                mbusy <= 1'b0;
                if (mem_read)  mrdata <= bus_mem[mem_address];
                if (mem_write) bus_mem[mem_address] <= mem_write_data;
            end else begin
                mcnt <= mcnt - 1;
            end
        end else if ((mem_read || mem_write) && ({mem_read, mem_write} != served)) begin
            mbusy  <= 1'b1;
            mcnt   <= lat;
            served <= {mem_read, mem_write};
        end else if (!mem_read && !mem_write) begin
            served <= 2'b00;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        rv  [8];
    logic        rdr [8];
    logic [3:0]  rt  [8];
    logic [15:0] rdat[8];
    logic [15:0] rmem[128];

    int          e_busy;
    logic        e_wb, e_al;
    logic [6:0]  e_wb_addr, e_al_addr;
    logic [15:0] e_wb_data;
    logic [7:0]  e_rd;

    task automatic model(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [3:0] tg;
        logic [2:0] ix;
        tg = a[7:4];
        ix = a[3:1];
        e_busy = 0; e_wb = 0; e_al = 0;
        e_wb_addr = '0; e_wb_data = '0; e_al_addr = '0; e_rd = '0;
        if (r ^ w) begin
            if (!(rv[ix] && rt[ix] == tg)) begin
                e_al = 1'b1;
                e_al_addr = a[7:1];
                e_busy = lat + 5;
                if (rv[ix] && rdr[ix]) begin
                    e_wb = 1'b1;
                    e_wb_addr = {rt[ix], ix};
                    e_wb_data = rdat[ix];
                    rmem[{rt[ix], ix}] = rdat[ix];
                    e_busy += lat + 3;
                end
                rv[ix] = 1'b1; rdr[ix] = 1'b0; rt[ix] = tg;
                rdat[ix] = rmem[a[7:1]];
            end
            if (w) begin
                if (a[0]) rdat[ix][15:8] = d;
                else      rdat[ix][7:0]  = d;
                rdr[ix] = 1'b1;
            end
            e_rd = a[0] ? rdat[ix][15:8] : rdat[ix][7:0];
        end
    endtask

    // ---------------- access driver / observer ----------------
    int          o_busy;
    logic        o_wb, o_al, o_both, o_order_bad, o_timeout, o_idle_req;
    logic [6:0]  o_wb_addr, o_al_addr;
    logic [15:0] o_wb_data;
    logic [7:0]  o_rdata;

    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic done;
        @(posedge clk); #1;
        read = r; write = w; address = a; write_data = d;
        o_busy = 0; o_wb = 0; o_al = 0; o_both = 0; o_order_bad = 0; o_timeout = 0;
        o_wb_addr = '0; o_al_addr = '0; o_wb_data = '0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!busy_wait) begin
                done = 1'b1;
            end else begin
                o_busy++;
                if (mem_read && mem_write) o_both = 1'b1;
                if (mem_write) begin
                    if (o_al) o_order_bad = 1'b1;
                    o_wb = 1'b1; o_wb_addr = mem_address; o_wb_data = mem_write_data;
                end
                if (mem_read) begin
                    o_al = 1'b1; o_al_addr = mem_address;
                end
                if (o_busy > 100) begin
                    o_timeout = 1'b1; done = 1'b1;
                end
            end
        end
        o_rdata = read_data;
        o_idle_req = mem_read | mem_write;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic run(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d, input string nm);
        model(r, w, a, d);
        access(r, w, a, d);
        chk({nm, ".timeout"}, o_timeout, 1'b0);
        chk({nm, ".busy_cycles"}, o_busy, e_busy);
        chk({nm, ".writeback"}, o_wb, e_wb);
        chk({nm, ".allocate"}, o_al, e_al);
        chk({nm, ".rd_wr_overlap"}, o_both, 1'b0);
        chk({nm, ".wb_before_alloc"}, o_order_bad, 1'b0);
        chk({nm, ".idle_mem_req"}, o_idle_req, 1'b0);
        if (e_wb) begin
            chk({nm, ".wb_addr"}, o_wb_addr, e_wb_addr);
            chk({nm, ".wb_data"}, o_wb_data, e_wb_data);
        end
        if (e_al) chk({nm, ".al_addr"}, o_al_addr, e_al_addr);
        if (r && !w) chk({nm, ".read_data"}, o_rdata, e_rd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rd, wr;
        logic [7:0] addr, wdata;
        logic       stall, wb, al, chk_rd;
        logic [6:0] wb_addr;
        logic [15:0] wb_data;
        logic [6:0] al_addr;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [15:0] v;
        int bound;
        rst = 1'b0; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
        lat = 1;
        for (int i = 0; i < 128; i++) begin
            v = 16'($urandom);
            if (i == 'h78) v = 16'hA55A;
            if (i == 'h58) v = 16'h1234;
            if (i == 'h17) v = 16'h0BEE;
            if (i == 'h07) v = 16'h7788;
            bus_mem[i] <= v;
            rmem[i] = v;
        end
        for (int i = 0; i < 8; i++) begin
            rv[i] = 1'b0; rdr[i] = 1'b0; rt[i] = '0; rdat[i] = '0;
        end

        tbl[0]  = '{1'b1, 1'b0, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 7'h00, 16'h0000, 7'h78, 8'h5A};
        tbl[1]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000, 7'h00, 8'hA5};
        tbl[2]  = '{1'b0, 1'b1, 8'hF1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 7'h00, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 8'hF1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000, 7'h00, 8'h3C};
        tbl[4]  = '{1'b1, 1'b0, 8'hB0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 7'h78, 16'h3C5A, 7'h58, 8'h34};
        tbl[5]  = '{1'b0, 1'b1, 8'h2E, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 16'h0000, 7'h17, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h2E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000, 7'h00, 8'hFF};
        tbl[7]  = '{1'b1, 1'b0, 8'h2F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000, 7'h00, 8'h0B};
        tbl[8]  = '{1'b1, 1'b1, 8'h2E, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 7'h00, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 8'h2E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000, 7'h00, 8'hFF};
        tbl[10] = '{1'b1, 1'b0, 8'h0E, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 7'h17, 16'h0BFF, 7'h07, 8'h88};

        // Reset state with reset held.
        repeat (3) @(negedge clk);
        chk("reset.busy_wait", busy_wait, 1'b0);
        chk("reset.mem_read", mem_read, 1'b0);
        chk("reset.mem_write", mem_write, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        // Reset pulsed in the middle of ALLOCATE.
        lat = 3;
        @(posedge clk); #1;
        read = 1'b1; address = 8'hF0;
        bound = 0;
        while (!mem_read && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("rstmid.alloc_reached", mem_read, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid.mem_read", mem_read, 1'b0);
        chk("rstmid.mem_write", mem_write, 1'b0);
        chk("rstmid.busy_wait", busy_wait, 1'b0);
        read = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rv[i] = 1'b0; rdr[i] = 1'b0;
        end

        // Directed table, checked against both the table and the model.
        lat = 1;
        for (int i = 0; i < 11; i++) begin
            run(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_stall", i), (o_busy != 0), tbl[i].stall);
            chk($sformatf("vec%0d.tbl_wb", i), o_wb, tbl[i].wb);
            chk($sformatf("vec%0d.tbl_al", i), o_al, tbl[i].al);
            if (tbl[i].wb) begin
                chk($sformatf("vec%0d.tbl_wb_addr", i), o_wb_addr, tbl[i].wb_addr);
                chk($sformatf("vec%0d.tbl_wb_data", i), o_wb_data, tbl[i].wb_data);
            end
            if (tbl[i].al) chk($sformatf("vec%0d.tbl_al_addr", i), o_al_addr, tbl[i].al_addr);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d.tbl_rdata", i), o_rdata, tbl[i].rdata);
        end

        // Randomized traffic over a few tags so hits, clean and dirty misses mix.
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            int op;
            a = {4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            op = $urandom_range(0, 9);
            lat = $urandom_range(0, 3);
            if (op == 0)      run(1'b1, 1'b1, a, 8'($urandom), $sformatf("rnd%0d", n));
            else if (op < 6)  run(1'b1, 1'b0, a, 8'h00, $sformatf("rnd%0d", n));
            else              run(1'b0, 1'b1, a, 8'($urandom), $sformatf("rnd%0d", n));
        end

        // Memory contents reflect every write-back the model predicted.
        @(posedge clk); #1;
        for (int i = 0; i < 128; i++)
            chk($sformatf("mem[%0h]", i), bus_mem[i], rmem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Write-back, direct-mapped data-cache controller between the processor's load/store path and the 16-bit-block data memory. It holds 8 lines of one 16-bit block each, answers hits with no stall, and handles misses on its own. On a miss it writes back a dirty victim, fetches the missing block, and stalls the processor with `busy_wait` until the access can complete as a hit. It replaces the ad-hoc miss handling in the existing cache and adds the dirty-eviction path.

## Interface
Parameters:
- TAG_W, 4, tag bits (address[7:4])
- INDEX_W, 3, index bits (address[3:1]); LINES = 2**INDEX_W = 8
- Offset is fixed at 1 bit (address[0]); 0 selects block[7:0], 1 selects block[15:8]

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- read  in  1  processor load request; held until busy_wait is low
- write  in  1  processor store request; held until busy_wait is low
- address  in  8  byte address {tag, index, offset}
- write_data  in  8  store data
- read_data  out  8  load data; valid when read=1 and busy_wait=0
- busy_wait  out  1  processor stall
- mem_read  out  1  block fetch request to data memory
- mem_write  out  1  block write-back request to data memory
- mem_address  out  7  block address {tag, index}
- mem_write_data  out  16  victim block
- mem_read_data  in  16  fetched block
- mem_busy_wait  in  1  memory busy; high while a request is in progress

## Operation
- Line storage: valid, dirty, tag[3:0] and data[15:0] per line.
- Hit: `hit = valid[index] & (tag[index] == address[7:4])`.
- Active request: `req = read ^ write`. read=write=1 is a no-op: busy_wait=0 and no state change.
- IDLE:
  - Read hit: read_data is the selected byte, combinational from address. busy_wait=0.
  - Write hit: busy_wait=0. On the next posedge, write_data goes into the selected byte and dirty is set to 1.
  - Miss with victim valid & dirty: busy_wait=1, go to WRITEBACK.
  - Any other miss: busy_wait=1, go to ALLOCATE.
- WRITEBACK:
  - Drives mem_write=1, mem_address={victim tag, index}, mem_write_data=victim data.
  - Exits to ALLOCATE at the first posedge where mem_busy_wait=0 and the state has lasted at least 2 cycles.
- ALLOCATE:
  - Drives mem_read=1, mem_address=address[7:1].
  - Exits to UPDATE under the same rule as WRITEBACK.
- UPDATE (1 cycle):
  - On the posedge, loads the line with mem_read_data, tag=address[7:4], valid=1, dirty=0.
  - Returns to IDLE, where the held request now hits. A store hit sets dirty=1.
- busy_wait is 1 in every state other than IDLE, and in IDLE whenever there is a miss with req=1.
- mem_read and mem_write are never asserted together. Both are 0 in IDLE and UPDATE.
- Reset (rst=0, any time):
  - State goes to IDLE. All valid and dirty bits clear.
  - mem_read, mem_write and busy_wait go to 0 immediately.
  - An in-flight memory transaction is abandoned.
  - Tag and data contents are don't-care.

## Timing
- Hit latency is 0 cycles of stall. Read data is combinational; write data commits at the next posedge.
- Clean miss: 1 detect cycle, then ALLOCATE for N_mem cycles, then 1 UPDATE cycle, then a hit in IDLE.
- Dirty miss: the clean-miss sequence plus WRITEBACK for N_mem cycles.
- The address must stay stable while busy_wait=1. A change of address or request mid-miss is not supported; the controller finishes the original block first.
- Request outputs are driven from state only. They are registered-stable and glitch-free toward memory.

## Structure
- Package `dcache_pkg`:
  - state enum: IDLE, WRITEBACK, ALLOCATE, UPDATE
  - TAG_W, INDEX_W, BLOCK_W=16, WORD_W=8
  - field-slice helpers for tag, index and offset
- One sub-module, `dcache_line_store`:
  - valid, dirty, tag and data arrays
  - asynchronous read port
  - single write port with byte-write or full-block-fill modes
  - clears valid/dirty on rst
- FSM and hit logic live in `dcache_ctrl`.

## Test plan
- **Reset:** pulse rst=0 mid-ALLOCATE. mem_read and busy_wait drop to 0 within the same cycle. After release, read of 0xF0 misses.
- **Clean read miss then hit:** memory block 0x78 holds 0xA55A.
  - read 0xF0: busy_wait=1, mem_read=1 and mem_address=0x78 until memory finishes, 1 UPDATE cycle.
  - Then read_data=0x5A with busy_wait=0. Read 0xF1 gives 0xA5 with no stall.
- **Write hit:** after the read miss above, write 0xF1 with 0x3C. No stall; next read of 0xF1 gives 0x3C. Line 0 is dirty.
- **Dirty eviction:** then read 0xB0 (same index 0, tag 0xB).
  - WRITEBACK first, with mem_write=1, mem_address=0x78, mem_write_data=0x3C5A.
  - Then ALLOCATE with mem_address=0x58.
  - mem_read and mem_write are never high together.
- **Write miss, clean victim:** write 0x2E with 0xFF. Block 0x17 is fetched, then 0xFF is merged into the low byte. Read 0x2E gives 0xFF; the line is dirty.
- **read=write=1:** busy_wait=0, no memory request, line contents unchanged.
